// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge
// -----------------------------------------------------------------------------
// Single-master bridge from the CPU data port to the memory-mapped slaves
// (data RAM and the LED peripheral). Each CPU request is decoded once and
// becomes a one-cycle read or write strobe to at most one slave. Read data
// returns with a one-cycle ack pulse. Accesses to unmapped addresses complete
// with an error flag and issue no strobe.
//
// Ports
//   clk, rst          : clock and asynchronous active-high reset
//   cpu_req_i         : request, sampled only while idle
//   cpu_we_i          : 1 = write, 0 = read
//   cpu_addr_i        : byte address
//   cpu_wdata_i       : write data
//   cpu_rdata_o       : read data; valid with ack, held until the next read ack
//   cpu_ack_o         : one-cycle completion pulse
//   cpu_err_o         : unmapped access; valid only with ack
//   mem_*             : RAM strobes, full address, write data, read data
//   led_*             : LED strobes, window offset (0..15), write data, read data
// -----------------------------------------------------------------------------
module periph_bus_bridge #(
  parameter logic [31:0] MEM_SIZE    = 32'h0000_1000,
  parameter logic [31:0] LED_BASE    = 32'h8000_0000,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        led_rd_en_o,
  output logic        led_wr_en_o,
  output logic [31:0] led_addr_o,
  output logic [31:0] led_wdata_o,
  input  logic [31:0] led_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_MEM  = 2'd1,
    T_LED  = 2'd2
  } target_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LATENCY);

  state_t      r_state;
  state_t      w_state_next;
  target_t     r_target;
  target_t     w_target_dec;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;
  logic        w_mem_read;

  // Address decode of the live CPU address; only used in the capture cycle.
  always_comb begin
    w_target_dec = T_NONE;
    if (cpu_addr_i < MEM_SIZE) begin
      w_target_dec = T_MEM;
    end else if (cpu_addr_i[31:4] == LED_BASE[31:4]) begin
      w_target_dec = T_LED;
    end
  end

  // A RAM read is the only access that may need to wait for the slave.
  assign w_mem_read = (r_target == T_MEM) && !r_we;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req_i) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_mem_read && (MEM_LATENCY != 0)) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_RESP;
        end
      end
      S_WAIT: begin
        // The counter is loaded with the latency, so a value of 1 marks the
        // cycle in which the RAM data is valid.
        if (r_cnt <= 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= T_NONE;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_cnt    <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req_i) begin
            r_target <= w_target_dec;
            r_we     <= cpu_we_i;
            r_addr   <= cpu_addr_i;
            r_wdata  <= cpu_wdata_i;
          end
        end
        S_ISSUE: begin
          if (w_mem_read && (MEM_LATENCY != 0)) begin
            r_cnt <= LAT4;
          end else if (!r_we) begin
            // Writes leave the previous read data untouched.
            case (r_target)
              T_MEM:   r_rdata <= mem_rdata_i;
              T_LED:   r_rdata <= led_rdata_i;
              default: r_rdata <= 32'h0;
            endcase
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_rdata <= mem_rdata_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes are decoded from the registered state, so they are one-hot and
  // last exactly the single ISSUE cycle.
  assign mem_rd_en_o = (r_state == S_ISSUE) && (r_target == T_MEM) && !r_we;
  assign mem_wr_en_o = (r_state == S_ISSUE) && (r_target == T_MEM) &&  r_we;
  assign led_rd_en_o = (r_state == S_ISSUE) && (r_target == T_LED) && !r_we;
  assign led_wr_en_o = (r_state == S_ISSUE) && (r_target == T_LED) &&  r_we;

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  // The LED window is 16-byte aligned, so the offset from its base is just
  // the low nibble of the address.
  assign led_addr_o  = {28'h0, r_addr[3:0]};
  assign led_wdata_o = r_wdata;

  assign cpu_ack_o   = (r_state == S_RESP);
  assign cpu_err_o   = (r_state == S_RESP) && (r_target == T_NONE);
  assign cpu_rdata_o = r_rdata;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// tb_periph_bus_bridge
// Directed stimulus for periph_bus_bridge with a transaction-level reference
// model: for every accepted request the model predicts the strobe cycle, the
// ack cycle, the error flag and the read data, and a compare process checks
// the DUT outputs against these predictions on every falling edge.
module tb_periph_bus_bridge;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'h0;
  logic [31:0] cpu_wdata_i = 32'h0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ack_o;
  logic        cpu_err_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        led_rd_en_o;
  logic        led_wr_en_o;
  logic [31:0] led_addr_o;
  logic [31:0] led_wdata_o;
  logic [31:0] led_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  periph_bus_bridge #(
    .MEM_SIZE   (32'h0000_1000),
    .LED_BASE   (32'h8000_0000),
    .MEM_LATENCY(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_ack_o  (cpu_ack_o),
    .cpu_err_o  (cpu_err_o),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .led_rd_en_o(led_rd_en_o),
    .led_wr_en_o(led_wr_en_o),
    .led_addr_o (led_addr_o),
    .led_wdata_o(led_wdata_o),
    .led_rdata_i(led_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- slave models ----------------
  logic [31:0] slave_ram [0:1023];
  logic [31:0] slave_led = 32'h0000_5A5A;
  logic [31:0] pipe_d [0:L-1];
  logic        pipe_v [0:L-1];

  initial begin
    for (int i = 0; i < 1024; i++) slave_ram[i] = i * 32'h0101_0101;
    for (int i = 0; i < L; i++) begin pipe_d[i] = 32'h0; pipe_v[i] = 1'b0; end
  end

  // RAM returns data L cycles after the rd_en cycle, garbage otherwise.
  always @(posedge clk) begin
    if (mem_wr_en_o) slave_ram[mem_addr_o[11:2]] <= mem_wdata_o;
    pipe_v[0] <= mem_rd_en_o;
    pipe_d[0] <= slave_ram[mem_addr_o[11:2]];
    for (int i = 1; i < L; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    if (led_wr_en_o) slave_led <= led_wdata_o;
  end
  assign mem_rdata_i = pipe_v[L-1] ? pipe_d[L-1] : 32'hBAD0_BAD0;
  assign led_rdata_i = slave_led;

  // ---------------- reference model ----------------
  typedef enum int {K_MEMRD, K_MEMWR, K_LEDRD, K_LEDWR, K_NONE} kind_t;

  logic [31:0] model_ram [0:1023];
  logic [31:0] model_led = 32'h0000_5A5A;
  initial for (int i = 0; i < 1024; i++) model_ram[i] = i * 32'h0101_0101;

  int          cyc = 0;
  bit          p_valid = 0;
  int          p_strobe = 0;
  int          p_ack = 0;
  kind_t       p_kind = K_NONE;
  bit          p_rd = 0;
  logic [31:0] p_addr = 0;
  logic [31:0] p_wdata = 0;
  logic [31:0] p_rdata = 0;
  logic [31:0] exp_rdata = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;  // index of the cycle that starts now
    if (rst) begin
      p_valid   = 0;
      exp_rdata = 32'h0;
    end else if (p_valid) begin
      if (cyc - 1 == p_ack) p_valid = 0;
    end else if (cpu_req_i) begin
      logic [31:0] a;
      a       = cpu_addr_i;
      p_valid = 1;
      p_rd    = !cpu_we_i;
      p_addr  = a;
      p_wdata = cpu_wdata_i;
      if (a < 32'h1000)
        p_kind = p_rd ? K_MEMRD : K_MEMWR;
      else if (a >= 32'h8000_0000 && a <= 32'h8000_000F)
        p_kind = p_rd ? K_LEDRD : K_LEDWR;
      else
        p_kind = K_NONE;
      p_strobe = cyc;
      p_ack    = cyc + 1 + ((p_kind == K_MEMRD) ? L : 0);
      case (p_kind)
        K_MEMRD: p_rdata = model_ram[a[11:2]];
        K_MEMWR: model_ram[a[11:2]] = p_wdata;
        K_LEDRD: p_rdata = model_led;
        K_LEDWR: model_led = p_wdata;
        default: p_rdata = 32'h0;
      endcase
    end
    if (p_valid && cyc == p_ack && p_rd) exp_rdata = p_rdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_strobes", {28'h0, mem_rd_en_o, mem_wr_en_o, led_rd_en_o, led_wr_en_o}, 32'h0);
      check("rst_ack_err", {30'h0, cpu_ack_o, cpu_err_o}, 32'h0);
      check("rst_rdata", cpu_rdata_o, 32'h0);
      check("rst_addr", mem_addr_o | led_addr_o, 32'h0);
      check("rst_wdata", mem_wdata_o | led_wdata_o, 32'h0);
    end else begin
      bit iss;
      bit ack;
      iss = p_valid && (cyc == p_strobe);
      ack = p_valid && (cyc == p_ack);
      check("mem_rd_en", {31'h0, mem_rd_en_o}, {31'h0, iss && p_kind == K_MEMRD});
      check("mem_wr_en", {31'h0, mem_wr_en_o}, {31'h0, iss && p_kind == K_MEMWR});
      check("led_rd_en", {31'h0, led_rd_en_o}, {31'h0, iss && p_kind == K_LEDRD});
      check("led_wr_en", {31'h0, led_wr_en_o}, {31'h0, iss && p_kind == K_LEDWR});
      check("ack", {31'h0, cpu_ack_o}, {31'h0, ack});
      if (ack) check("err", {31'h0, cpu_err_o}, {31'h0, p_kind == K_NONE});
      check("rdata", cpu_rdata_o, exp_rdata);
      if (iss && (p_kind == K_MEMRD || p_kind == K_MEMWR)) begin
        check("mem_addr", mem_addr_o, p_addr);
        if (p_kind == K_MEMWR) check("mem_wdata", mem_wdata_o, p_wdata);
      end
      if (iss && (p_kind == K_LEDRD || p_kind == K_LEDWR)) begin
        check("led_addr", led_addr_o, p_addr - 32'h8000_0000);
        if (p_kind == K_LEDWR) check("led_wdata", led_wdata_o, p_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = d;
  endtask

  // Drops req after the sample edge, scrambles the inputs to show they were
  // captured, then waits (bounded) for ack and checks the hand-computed values.
  task automatic finish(input string nm, input int exp_n, input logic exp_err,
                        input logic [31:0] exp_d);
    int n;
    @(negedge clk);
    cpu_req_i   = 1'b0;
    cpu_addr_i  = 32'h8000_000C;
    cpu_wdata_i = ~cpu_wdata_i;
    cpu_we_i    = ~cpu_we_i;
    n = 1;
    while (!cpu_ack_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    $display("txn %s: ack after %0d cycles, err=%0b, rdata=%h", nm, n, cpu_err_o, cpu_rdata_o);
    check({nm, "_latency"}, n, exp_n);
    check({nm, "_err"}, {31'h0, cpu_err_o}, {31'h0, exp_err});
    check({nm, "_rdata"}, cpu_rdata_o, exp_d);
  endtask

  task automatic txn(input string nm, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input int exp_n, input logic exp_err,
                     input logic [31:0] exp_d);
    start(we, a, d);
    finish(nm, exp_n, exp_err, exp_d);
  endtask

  initial begin
    int acks;
    int n;
    int last;
    // Reset held with a pending request: nothing may happen.
    rst         = 1'b1;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h8000_0008;
    repeat (4) @(negedge clk);
    check("rst_hold_ack", {31'h0, cpu_ack_o}, 32'h0);
    rst = 1'b0;
    finish("first_after_rst", 2, 1'b0, 32'h0000_5A5A);

    txn("led_wr", 1'b1, 32'h8000_0000, 32'h0000_00A5, 2, 1'b0, 32'h0000_5A5A);
    txn("led_rd", 1'b0, 32'h8000_0004, 32'h0,         2, 1'b0, 32'h0000_00A5);
    txn("ram_wr", 1'b1, 32'h0000_0FFC, 32'h1234_5678, 2, 1'b0, 32'h0000_00A5);
    txn("ram_rd", 1'b0, 32'h0000_0FFC, 32'h0,         5, 1'b0, 32'h1234_5678);
    txn("ram_top", 1'b0, 32'h0000_0FFF, 32'h0,        5, 1'b0, 32'h1234_5678);
    txn("ram_lo", 1'b0, 32'h0000_0010, 32'h0,         5, 1'b0, 32'h0404_0404);
    txn("unmap_rd", 1'b0, 32'h4000_0000, 32'h0,       2, 1'b1, 32'h0);
    txn("led_end_rd", 1'b0, 32'h8000_000F, 32'h0,     2, 1'b0, 32'h0000_00A5);
    txn("led_past_wr", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 2, 1'b1, 32'h0000_00A5);
    txn("mem_size_rd", 1'b0, 32'h0000_1000, 32'h0,    2, 1'b1, 32'h0);

    // Back-to-back: req held through three LED reads.
    start(1'b0, 32'h8000_0008, 32'h0);
    acks = 0; n = 0; last = -1;
    while (acks < 3 && n < 30) begin
      @(negedge clk);
      n++;
      if (cpu_ack_o) begin
        acks++;
        $display("txn b2b_%0d: ack at cycle offset %0d, rdata=%h", acks, n, cpu_rdata_o);
        if (acks == 3) cpu_req_i = 1'b0;
        if (last >= 0) check("b2b_gap", n - last, 3);
        last = n;
      end
    end
    check("b2b_acks", acks, 3);
    check("b2b_rdata", cpu_rdata_o, 32'h0000_00A5);

    // Reset in the middle of a RAM read wait.
    start(1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    cpu_req_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack_o) acks++;
    end
    $display("txn rst_mid_wait: %0d acks after reset", acks);
    check("rst_mid_wait_acks", acks, 0);
    check("rst_mid_wait_rdata", cpu_rdata_o, 32'h0);
    txn("after_rst_led", 1'b0, 32'h8000_0000, 32'h0, 2, 1'b0, 32'h0000_00A5);
    txn("after_rst_ram", 1'b0, 32'h0000_0100, 32'h0, 5, 1'b0, 32'h4040_4040);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
